// File: rtl/clk_reset_seq_pkg.sv
// clk_reset_seq_pkg: shared FSM state encoding and width helper for the reset sequencer
package clk_reset_seq_pkg;

    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_HOLD      = 2'd1;
    localparam logic [1:0] ST_RELEASE   = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/clk_reset_seq_sync.sv
// sync2: two-flop synchroniser for a single asynchronous input
//   clk  in   destination clock
//   rst  in   asynchronous active-high reset, clears both flops
//   d    in   asynchronous input
//   q    out  synchronised output, follows d after two clk edges
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/clk_reset_seq.sv
// clk_reset_seq: clock-enable divider and ordered per-domain reset sequencer
//   clk           in   fast PLL clock
//   reset         in   asynchronous active-high board reset
//   pll_locked    in   PLL lock, asynchronous to clk
//   domain_ready  in   per-domain ready flags, synchronous to clk
//   err_clear     in   clears sticky status flags
//   ce            out  one-cycle clock-enable pulses, ce[k] every 2^(k+1) cycles
//   domain_reset  out  registered active-high reset per domain
//   all_ready     out  all domains released and masked readies met
//   lock_lost     out  sticky: lock dropped in RELEASE or RUN
//   timeout_err   out  sticky: a ready wait timed out
module clk_reset_seq
    import clk_reset_seq_pkg::*;
#(
    parameter int                     DIV_STAGES    = 2,
    parameter int                     RESET_CYCLES  = 15,
    parameter int                     NUM_DOMAINS   = 2,
    parameter logic [NUM_DOMAINS-1:0] READY_MASK    = NUM_DOMAINS'(1),
    parameter int                     READY_TIMEOUT = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pll_locked,
    input  logic [NUM_DOMAINS-1:0] domain_ready,
    input  logic                   err_clear,
    output logic [DIV_STAGES-1:0]  ce,
    output logic [NUM_DOMAINS-1:0] domain_reset,
    output logic                   all_ready,
    output logic                   lock_lost,
    output logic                   timeout_err
);

    localparam int HW = clog2_min1(RESET_CYCLES);
    localparam int IW = clog2_min1(NUM_DOMAINS);
    localparam int WW = clog2_min1(READY_TIMEOUT + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DOMAINS - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(READY_TIMEOUT);

    logic                   lock_s;
    logic [1:0]             state_q, state_d;
    logic [DIV_STAGES-1:0]  cnt_q, cnt_d;
    logic [DIV_STAGES-1:0]  ce_q, ce_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [WW-1:0]          wait_q, wait_d;
    logic [NUM_DOMAINS-1:0] domain_reset_q, domain_reset_d;
    logic                   all_ready_q, all_ready_d;
    logic                   lock_lost_q, lock_lost_d;
    logic                   timeout_err_q, timeout_err_d;
    logic                   ready_met, tmo_hit, advance, is_last;

    sync2 u_lock_sync (
        .clk (clk),
        .rst (reset),
        .d   (pll_locked),
        .q   (lock_s)
    );

    // ce[k] fires the cycle after the low k+1 counter bits are all ones
    for (genvar g = 0; g < DIV_STAGES; g++) begin : g_ce
        assign ce_d[g] = &cnt_q[g:0];
    end

    assign ready_met = !READY_MASK[idx_q] || domain_ready[idx_q];
    assign tmo_hit   = (READY_TIMEOUT != 0) && (wait_q == WAIT_LAST);
    assign advance   = (state_q == ST_RELEASE) && lock_s && (ready_met || tmo_hit);
    assign is_last   = idx_q == IDX_LAST;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_WAIT_LOCK;
            cnt_q          <= '0;
            ce_q           <= '0;
            hold_q         <= '0;
            idx_q          <= '0;
            wait_q         <= '0;
            domain_reset_q <= '1;
            all_ready_q    <= 1'b0;
            lock_lost_q    <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ce_q           <= ce_d;
            hold_q         <= hold_d;
            idx_q          <= idx_d;
            wait_q         <= wait_d;
            domain_reset_q <= domain_reset_d;
            all_ready_q    <= all_ready_d;
            lock_lost_q    <= lock_lost_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_LOCK: state_d = lock_s ? ST_HOLD : ST_WAIT_LOCK;
            ST_HOLD:      state_d = !lock_s ? ST_WAIT_LOCK : (hold_q == HOLD_LAST) ? ST_RELEASE : ST_HOLD;
            ST_RELEASE:   state_d = !lock_s ? ST_WAIT_LOCK : (advance && is_last) ? ST_RUN : ST_RELEASE;
            default:      state_d = lock_s ? ST_RUN : ST_WAIT_LOCK;
        endcase
    end

    // lock loss forces every domain back into reset before any advance is honoured
    always_comb begin
        cnt_d          = lock_s ? cnt_q + 1'b1 : '0;
        hold_d         = (state_q == ST_HOLD && state_d == ST_HOLD) ? hold_q + 1'b1 : '0;
        idx_d          = (state_q != ST_RELEASE) ? '0 : (advance && !is_last) ? idx_q + 1'b1 : idx_q;
        wait_d         = (state_q == ST_RELEASE && !advance && READY_TIMEOUT != 0) ? wait_q + 1'b1 : '0;
        domain_reset_d = (!lock_s || state_q == ST_WAIT_LOCK) ? '1 :
                         (state_q == ST_HOLD && hold_q == HOLD_LAST) ? domain_reset_q & ~NUM_DOMAINS'(1) :
                         (advance && !is_last) ? domain_reset_q & ~(NUM_DOMAINS'(2) << idx_q) :
                         domain_reset_q;
        all_ready_d    = state_d == ST_RUN;
        lock_lost_d    = (!lock_s && (state_q == ST_RELEASE || state_q == ST_RUN)) || (lock_lost_q && !err_clear);
        timeout_err_d  = (advance && tmo_hit && !ready_met) || (timeout_err_q && !err_clear);
    end

    assign ce           = ce_q;
    assign domain_reset = domain_reset_q;
    assign all_ready    = all_ready_q;
    assign lock_lost    = lock_lost_q;
    assign timeout_err  = timeout_err_q;

endmodule
